// File: rtl/sample_read_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// CCHW -- shared definitions for the sample read sequencer.
//   state_t    : read-handshake FSM states (IDLE, ISSUE, WAIT_LOW)
//   DEF_IN_W   : default codec channel width
//   DEF_OUT_W  : default output sample width
// Optional build macro used by the top: SAMPLE_SATURATE_EN.
// -----------------------------------------------------------------------------
package CCHW;

  localparam int DEF_IN_W  = 24;
  localparam int DEF_OUT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

endpackage : CCHW

// File: rtl/sample_read_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo -- synchronous FIFO holding mixed samples for the consumer.
//   clk, rst      : clock, asynchronous active-low reset
//   push, wr_data : write request (caller guarantees room or a same-cycle pop)
//   pop           : read request; ignored while empty
//   rd_data       : head entry, zero while empty
//   level         : number of entries held
//   full          : level == DEPTH
// Pointers wrap naturally because DEPTH is a power of two.
// -----------------------------------------------------------------------------
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic [LW-1:0] level,
  output logic          full
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          not_empty;
  logic          pop_ok;

  assign not_empty = (level != '0);
  assign full      = (level == FULL_LVL);
  assign pop_ok    = pop && not_empty;
  // Masking the head keeps smp_data at zero while empty without resetting storage.
  assign rd_data   = not_empty ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; only pointers and level are reset, which lets
  // the array map onto plain registers or RAM without a clear path.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule : sample_fifo

// File: rtl/sample_read_sequencer.sv
// -----------------------------------------------------------------------------
// sample_read_sequencer -- reads stereo samples from a codec with a one-cycle
// strobe, mixes left+right into a mono sample and queues it for a consumer.
//   clk, rst         : clock, asynchronous active-low reset
//   codec_read_ready : codec has a sample pending (level, may stay high)
//   codec_left/right : signed IN_W-bit channels
//   codec_read       : one-cycle read strobe (high only in ISSUE)
//   smp_data/valid   : FIFO head and its valid flag
//   smp_ready        : consumer accepts smp_data
//   fifo_level       : entries held
//   overrun_count    : samples dropped because the FIFO was full (saturating)
// Build option: define SAMPLE_SATURATE_EN to clamp out-of-range samples
// instead of wrapping.
// Assumes IN_W > OUT_W.
// -----------------------------------------------------------------------------
module sample_read_sequencer #(
  parameter int DEPTH = 4,
  parameter int IN_W  = CCHW::DEF_IN_W,
  parameter int OUT_W = CCHW::DEF_OUT_W,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             codec_read_ready,
  input  logic [IN_W-1:0]  codec_left,
  input  logic [IN_W-1:0]  codec_right,
  output logic             codec_read,
  output logic [OUT_W-1:0] smp_data,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic [LW-1:0]    fifo_level,
  output logic [7:0]       overrun_count
);

  import CCHW::*;

  state_t state;
  state_t state_nxt;

  logic [IN_W:0]    sum;
  logic [OUT_W-1:0] sample_trunc;
  logic [OUT_W-1:0] sample;
  logic             unused_bits;
  logic             fifo_full;
  logic             pop;
  logic             issue;
  logic             push;
  logic             drop;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    state_nxt  = state;
    codec_read = 1'b0;
    case (state)
      IDLE:     if (codec_read_ready) state_nxt = ISSUE;
      ISSUE: begin
        codec_read = 1'b1;
        state_nxt  = WAIT_LOW;
      end
      // Hold here until the level drops so a stuck-high ready gives one strobe.
      WAIT_LOW: if (!codec_read_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- mixing
  assign sum          = {codec_left[IN_W-1], codec_left} + {codec_right[IN_W-1], codec_right};
  assign sample_trunc = sum[IN_W-1 -: OUT_W];
  // Bits below the output slice and the extra sign bit are intentionally dropped.
  assign unused_bits  = ^{sum[IN_W], sum[IN_W-OUT_W-1:0]};

`ifdef SAMPLE_SATURATE_EN
  // The slice fits only if the extra sign bit agrees with the slice's MSB.
  always_comb begin
    sample = sample_trunc;
    if (sum[IN_W] != sum[IN_W-1])
      sample = sum[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end
`else
  assign sample = sample_trunc;
`endif

  // ---------------------------------------------------------------- FIFO
  assign pop   = smp_valid && smp_ready;
  assign issue = (state == ISSUE);
  // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
  assign push  = issue && (!fifo_full || pop);
  assign drop  = issue && fifo_full && !pop;

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (sample),
    .pop     (pop),
    .rd_data (smp_data),
    .level   (fifo_level),
    .full    (fifo_full)
  );

  assign smp_valid = (fifo_level != '0);

  // ---------------------------------------------------------------- overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 overrun_count <= '0;
    else if (drop && (overrun_count != 8'hFF)) overrun_count <= overrun_count + 8'd1;
  end

endmodule : sample_read_sequencer

// File: tb/tb_sample_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sample_read_sequencer -- directed self-checking bench for
// sample_read_sequencer (DEPTH=4, IN_W=24, OUT_W=16). Expected values are hand
// computed; the saturation case depends on SAMPLE_SATURATE_EN.
// -----------------------------------------------------------------------------
module tb_sample_read_sequencer;

  localparam int DEPTH = 4;
  localparam int IN_W  = 24;
  localparam int OUT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             codec_read_ready = 1'b0;
  logic [IN_W-1:0]  codec_left  = '0;
  logic [IN_W-1:0]  codec_right = '0;
  logic             codec_read;
  logic [OUT_W-1:0] smp_data;
  logic             smp_valid;
  logic             smp_ready = 1'b0;
  logic [LW-1:0]    fifo_level;
  logic [7:0]       overrun_count;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;
  int base;

  sample_read_sequencer #(
    .DEPTH (DEPTH),
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .codec_read_ready (codec_read_ready),
    .codec_left       (codec_left),
    .codec_right      (codec_right),
    .codec_read       (codec_read),
    .smp_data         (smp_data),
    .smp_valid        (smp_valid),
    .smp_ready        (smp_ready),
    .fifo_level       (fifo_level),
    .overrun_count    (overrun_count)
  );

  always #5 clk = ~clk;

  // Strobes seen at rising edges (pre-edge value of codec_read).
  always @(posedge clk) if (codec_read === 1'b1) strobes++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete read handshake; optionally pop during the ISSUE cycle.
  task automatic do_read(input logic [IN_W-1:0] l, input logic [IN_W-1:0] r, input logic pop_in_issue);
    codec_left       = l;
    codec_right      = r;
    codec_read_ready = 1'b1;
    tick();
    codec_read_ready = 1'b0;
    smp_ready        = pop_in_issue;
    check("strobe_in_issue", 32'(codec_read), 32'd1);
    tick();
    smp_ready = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    smp_ready = 1'b1;
    tick();
    smp_ready = 1'b0;
  endtask

  initial begin
    // ---- reset state
    #3;
    check("rst_codec_read", 32'(codec_read), 32'd0);
    check("rst_smp_valid", 32'(smp_valid), 32'd0);
    check("rst_smp_data", 32'(smp_data), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_overrun", 32'(overrun_count), 32'd0);
    #4 rst = 1'b1;
    tick();
    tick();

    // ---- single pulse: strobe at N+1, data at N+2
    codec_left       = 24'h000100;
    codec_right      = 24'h000200;
    codec_read_ready = 1'b1;
    tick();
    codec_read_ready = 1'b0;
    check("pulse_strobe", 32'(codec_read), 32'd1);
    check("pulse_no_valid_yet", 32'(smp_valid), 32'd0);
    tick();
    check("pulse_strobe_low", 32'(codec_read), 32'd0);
    check("pulse_valid", 32'(smp_valid), 32'd1);
    check("pulse_data", 32'(smp_data), 32'h0003);
    check("pulse_level", 32'(fifo_level), 32'd1);
    tick();
    pop_one();
    check("pulse_drained", 32'(fifo_level), 32'd0);
    check("pulse_valid_low", 32'(smp_valid), 32'd0);

    // ---- ready held high for 20 cycles: exactly one strobe
    base             = strobes;
    codec_read_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    codec_read_ready = 1'b0;
    tick();
    tick();
    check("held_one_strobe", 32'(strobes - base), 32'd1);
    check("held_level", 32'(fifo_level), 32'd1);
    check("held_data", 32'(smp_data), 32'h0003);
    pop_one();

    // ---- 6 samples into a 4-deep FIFO with no consumer
    for (int k = 1; k <= 6; k++) do_read({8'(k), 16'h0000} >> 8, 24'h0, 1'b0);
    check("ovr_level", 32'(fifo_level), 32'd4);
    check("ovr_count", 32'(overrun_count), 32'd2);
    for (int k = 1; k <= 4; k++) begin
      check("ovr_order", 32'(smp_data), 32'(k));
      pop_one();
    end
    check("ovr_empty", 32'(fifo_level), 32'd0);
    smp_ready = 1'b1;
    tick();
    smp_ready = 1'b0;
    check("pop_empty_ignored", 32'(fifo_level), 32'd0);
    check("pop_empty_valid", 32'(smp_valid), 32'd0);

    // ---- full FIFO with a pop in the ISSUE cycle
    for (int k = 0; k < 4; k++) do_read(24'(32'h1000 + (k << 8)), 24'h0, 1'b0);
    check("full_level", 32'(fifo_level), 32'd4);
    do_read(24'h002000, 24'h0, 1'b1);
    check("pushpop_level", 32'(fifo_level), 32'd4);
    check("pushpop_overrun", 32'(overrun_count), 32'd2);
    check("pushpop_head", 32'(smp_data), 32'h0011);
    pop_one();
    check("pushpop_2", 32'(smp_data), 32'h0012);
    pop_one();
    check("pushpop_3", 32'(smp_data), 32'h0013);
    pop_one();
    check("pushpop_4", 32'(smp_data), 32'h0020);
    pop_one();
    check("pushpop_empty", 32'(fifo_level), 32'd0);

    // ---- out-of-range sums
    do_read(24'h7FFF00, 24'h7FFF00, 1'b0);
`ifdef SAMPLE_SATURATE_EN
    check("sat_pos", 32'(smp_data), 32'h7FFF);
`else
    check("wrap_pos", 32'(smp_data), 32'hFFFE);
`endif
    pop_one();
    do_read(24'h800000, 24'h800000, 1'b0);
`ifdef SAMPLE_SATURATE_EN
    check("sat_neg", 32'(smp_data), 32'h8000);
`else
    check("wrap_neg", 32'(smp_data), 32'h0000);
`endif
    check("neg_valid", 32'(smp_valid), 32'd1);
    pop_one();

    // ---- overrun counter saturates at 255
    for (int k = 0; k < 4 + 260; k++) do_read(24'h000100, 24'h0, 1'b0);
    check("ovr_saturate", 32'(overrun_count), 32'd255);
    check("ovr_sat_level", 32'(fifo_level), 32'd4);

    // ---- reset during ISSUE
    codec_read_ready = 1'b1;
    tick();
    check("abort_in_issue", 32'(codec_read), 32'd1);
    codec_read_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_codec_read", 32'(codec_read), 32'd0);
    check("abort_valid", 32'(smp_valid), 32'd0);
    check("abort_data", 32'(smp_data), 32'd0);
    check("abort_level", 32'(fifo_level), 32'd0);
    check("abort_overrun", 32'(overrun_count), 32'd0);
    tick();
    check("abort_no_write", 32'(fifo_level), 32'd0);
    #2 rst = 1'b1;
    tick();
    base = strobes;
    do_read(24'h000100, 24'h000200, 1'b0);
    check("rearm_strobes", 32'(strobes - base), 32'd1);
    check("rearm_level", 32'(fifo_level), 32'd1);
    check("rearm_data", 32'(smp_data), 32'h0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sample_read_sequencer
